serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor.sv | 115 +++++++++++
 tb/tb_serial_subtractor.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Multi-cycle ripple-borrow subtractor: a - b - borrow_in, CHUNK bits per clock.
// Define SERIAL_SUBTRACTOR_OVERFLOW_EN to build the signed overflow flag.
module serial_subtractor #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow
);

    localparam int unsigned N    = WIDTH / CHUNK;
    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;

    if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
        $error("serial_subtractor: CHUNK must divide WIDTH and satisfy 1 <= CHUNK <= WIDTH");
    end

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, b_q, partial_q, partial_nxt;
    logic              borrow_q;
    logic [IdxW-1:0]   idx_q;
    logic [CHUNK:0]    chunk_res;
    logic              last;
    logic [WIDTH-1:0]  diff_q;
    logic              borrow_out_q;

    // One CHUNK-bit borrow chain per cycle; the extra MSB is the outgoing borrow.
    always_comb begin
        chunk_res = {1'b0, a_q[idx_q*CHUNK +: CHUNK]} - {1'b0, b_q[idx_q*CHUNK +: CHUNK]}
                    - {{CHUNK{1'b0}}, borrow_q};
        partial_nxt = partial_q;
        partial_nxt[idx_q*CHUNK +: CHUNK] = chunk_res[CHUNK-1:0];
        last = (idx_q == IdxW'(N - 1));
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StRun;
            StRun:   if (last) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q          <= '0;
            b_q          <= '0;
            borrow_q     <= 1'b0;
            idx_q        <= '0;
            partial_q    <= '0;
            diff_q       <= '0;
            borrow_out_q <= 1'b0;
        end else begin
            if (state_q == StIdle && start) begin
                a_q       <= a;
                b_q       <= b;
                borrow_q  <= borrow_in;
                idx_q     <= '0;
                partial_q <= '0;
            end else if (state_q == StRun) begin
                partial_q <= partial_nxt;
                borrow_q  <= chunk_res[CHUNK];
                idx_q     <= idx_q + 1'b1;
                if (last) begin
                    diff_q       <= partial_nxt;
                    borrow_out_q <= chunk_res[CHUNK];
                end
            end
        end
    end

`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    logic overflow_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
        end else if (state_q == StRun && last) begin
            overflow_q <= (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                          (partial_nxt[WIDTH-1] != a_q[WIDTH-1]);
        end
    end

    assign overflow = overflow_q;
`else
    assign overflow = 1'b0;
`endif

    assign busy       = (state_q == StRun);
    assign done       = (state_q == StDone);
    assign diff       = diff_q;
    assign borrow_out = borrow_out_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=32, CHUNK=8, N=4).
module tb_serial_subtractor;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] a, b;
    logic        borrow_in;
    logic        busy, done, borrow_out, overflow;
    logic [31:0] diff;

    int tests_run = 0;
    int tests_failed = 0;

`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    localparam logic OvfOn = 1'b1;
`else
    localparam logic OvfOn = 1'b0;
`endif

    serial_subtractor #(.WIDTH(32), .CHUNK(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .borrow_in  (borrow_in),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Accept an op at the next edge (E0), then count edges until done is seen.
    task automatic do_op(input logic [31:0] av, input logic [31:0] bv, input logic bin,
                         output int lat);
        @(negedge clk);
        a = av; b = bv; borrow_in = bin; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; borrow_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if ({busy, done, borrow_out, overflow} !== 4'b0000 || diff !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_outputs: busy=%b done=%b diff=%h bo=%b ovf=%b, required all 0",
                     busy, done, diff, borrow_out, overflow);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int lat;
        do_op(32'h5, 32'h3, 1'b0, lat);
        tests_run++;
        if (lat !== 4) begin
            tests_failed++;
            $display("FAIL basic_latency: got %0d edges, required 4", lat);
        end
        tests_run++;
        if (diff !== 32'h2 || borrow_out !== 1'b0 || overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_result: diff=%h bo=%b ovf=%b, required 00000002 0 0",
                     diff, borrow_out, overflow);
        end
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_busy_at_done: busy=%b, required 0", busy);
        end
        @(posedge clk); #1;
        tests_run++;
        if (done !== 1'b0 || diff !== 32'h2) begin
            tests_failed++;
            $display("FAIL basic_done_pulse: done=%b diff=%h, required 0 00000002", done, diff);
        end
    endtask

    task automatic test_cross_borrow();
        int lat;
        do_op(32'h01000000, 32'h1, 1'b0, lat);
        tests_run++;
        if (lat !== 4 || diff !== 32'h00FFFFFF || borrow_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL cross_chunk: lat=%0d diff=%h bo=%b, required 4 00ffffff 0",
                     lat, diff, borrow_out);
        end
        @(posedge clk); #1;
        do_op(32'h0, 32'h1, 1'b0, lat);
        tests_run++;
        if (lat !== 4 || diff !== 32'hFFFFFFFF || borrow_out !== 1'b1 || overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL zero_minus_one: lat=%0d diff=%h bo=%b ovf=%b, required 4 ffffffff 1 0",
                     lat, diff, borrow_out, overflow);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_borrow_in();
        int lat;
        do_op(32'h12345678, 32'h12345678, 1'b1, lat);
        tests_run++;
        if (lat !== 4 || diff !== 32'hFFFFFFFF || borrow_out !== 1'b1) begin
            tests_failed++;
            $display("FAIL borrow_in_equal: lat=%0d diff=%h bo=%b, required 4 ffffffff 1",
                     lat, diff, borrow_out);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_overflow();
        int lat;
        do_op(32'h80000000, 32'h1, 1'b0, lat);
        tests_run++;
        if (lat !== 4 || diff !== 32'h7FFFFFFF || borrow_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL signed_ovf_result: lat=%0d diff=%h bo=%b, required 4 7fffffff 0",
                     lat, diff, borrow_out);
        end
        tests_run++;
        if (overflow !== OvfOn) begin
            tests_failed++;
            $display("FAIL signed_ovf_flag: ovf=%b, required %b", overflow, OvfOn);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_ignore_start();
        int lat;
        int extra_done;
        @(negedge clk);
        a = 32'd20; b = 32'd5; borrow_in = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            if (i == 3) begin
                a = 32'd9; b = 32'd9; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            if (done) begin
                lat = i;
                break;
            end
        end
        start = 1'b0;
        tests_run++;
        if (lat !== 4 || diff !== 32'd15) begin
            tests_failed++;
            $display("FAIL ignore_start_result: lat=%0d diff=%h, required 4 0000000f", lat, diff);
        end
        extra_done = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (done || busy) extra_done++;
        end
        tests_run++;
        if (extra_done !== 0 || diff !== 32'd15) begin
            tests_failed++;
            $display("FAIL ignore_start_queued: extra busy/done cycles=%0d diff=%h, required 0 0000000f",
                     extra_done, diff);
        end
    endtask

    task automatic test_held_start();
        int lat;
        int acc;
        do_op(32'd100, 32'd1, 1'b0, lat);
        tests_run++;
        if (lat !== 4 || diff !== 32'd99) begin
            tests_failed++;
            $display("FAIL held_first: lat=%0d diff=%h, required 4 00000063", lat, diff);
        end
        // Raise start during the DONE cycle and hold it until the block accepts.
        a = 32'd50; b = 32'd8; borrow_in = 1'b0; start = 1'b1;
        acc = -1;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk); #1;
            if (busy) begin
                acc = i;
                break;
            end
        end
        start = 1'b0;
        tests_run++;
        if (acc < 1 || acc > 2) begin
            tests_failed++;
            $display("FAIL held_accept: accepted %0d edges after DONE, required 1..2", acc);
        end
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = i;
                break;
            end
        end
        tests_run++;
        if (lat !== 4 || diff !== 32'd42) begin
            tests_failed++;
            $display("FAIL held_second: lat=%0d diff=%h, required 4 0000002a", lat, diff);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_op();
        int lat;
        int seen;
        @(negedge clk);
        a = 32'd100; b = 32'd1; borrow_in = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({busy, done, borrow_out, overflow} !== 4'b0000 || diff !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_mid_op: busy=%b done=%b diff=%h bo=%b ovf=%b, required all 0",
                     busy, done, diff, borrow_out, overflow);
        end
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (done || busy) seen++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (done || busy) seen++;
        end
        tests_run++;
        if (seen !== 0) begin
            tests_failed++;
            $display("FAIL reset_no_done: busy/done cycles=%0d, required 0", seen);
        end
        do_op(32'd7, 32'd2, 1'b0, lat);
        tests_run++;
        if (lat !== 4 || diff !== 32'd5 || borrow_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL after_reset_op: lat=%0d diff=%h bo=%b, required 4 00000005 0",
                     lat, diff, borrow_out);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_cross_borrow();
        test_borrow_in();
        test_overflow();
        test_ignore_start();
        test_held_start();
        test_reset_mid_op();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
